// File: rtl/div_iter_param.sv
// div_iter_param: iterative radix-2 restoring divider with RISC-V divide-by-zero/overflow handling.
// Define DIV_EARLY_OUT_EN to skip leading-zero steps of the dividend magnitude.
module div_iter_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             annul_i,
  input  logic             ack_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o,
  output logic             overflow_o
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dd_mag, dv_mag, pre_mag;
  logic [CW-1:0] cnt_q, cnt_ld;
  logic [WIDTH:0] rem_sh, diff;
  logic neg_q, dneg_q, accept, zero_div, ovf, zero_dd;
  assign accept = state == IDLE && start_i && !annul_i;
  assign dd_mag = signed_i && dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
  assign dv_mag = signed_i && divisor_i[WIDTH-1] ? -divisor_i : divisor_i;
  assign zero_div = divisor_i == '0;
  assign ovf = signed_i && dividend_i == MIN && &divisor_i;
`ifdef DIV_EARLY_OUT_EN
  logic [CW-1:0] lz;
  always_comb begin
    lz = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) if (dd_mag[i]) lz = CW'(WIDTH - 1 - i);
  end
  assign pre_mag = dd_mag << lz;
  assign cnt_ld = CW'(WIDTH) - lz;
  assign zero_dd = dd_mag == '0;
`else
  assign pre_mag = dd_mag;
  assign cnt_ld = CW'(WIDTH);
  assign zero_dd = 1'b0;
`endif
  // quo_q doubles as the dividend shift register; its MSB feeds the partial remainder
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff = rem_sh - {1'b0, dvs_q};
  assign busy_o = state != IDLE;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = accept ? (zero_div || ovf || zero_dd ? DONE : CALC) : IDLE;
    else if (annul_i) state_n = IDLE;
    else if (state == CALC) state_n = cnt_q == CW'(1) ? FIXUP : CALC;
    else if (state == FIXUP) state_n = DONE;
    else state_n = ack_i ? IDLE : DONE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      dneg_q <= 1'b0;
      valid_o <= 1'b0;
      div_zero_o <= 1'b0;
      overflow_o <= 1'b0;
      quotient_o <= '0;
      remainder_o <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        rem_q <= '0;
        quo_q <= pre_mag;
        dvs_q <= dv_mag;
        cnt_q <= cnt_ld;
        neg_q <= signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
        dneg_q <= signed_i && dividend_i[WIDTH-1];
        valid_o <= zero_div || ovf || zero_dd;
        div_zero_o <= zero_div;
        overflow_o <= ovf;
        if (zero_div) begin
          quotient_o <= '1;
          remainder_o <= dividend_i;
        end else if (ovf) begin
          quotient_o <= MIN;
          remainder_o <= '0;
        end else if (zero_dd) begin
          quotient_o <= '0;
          remainder_o <= '0;
        end
      end else if (state != IDLE && (annul_i || (state == DONE && ack_i))) begin
        valid_o <= 1'b0;
        div_zero_o <= 1'b0;
        overflow_o <= 1'b0;
      end else if (state == CALC) begin
        rem_q <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], !diff[WIDTH]};
        cnt_q <= cnt_q - CW'(1);
      end else if (state == FIXUP) begin
        quotient_o <= neg_q ? -quo_q : quo_q;
        remainder_o <= dneg_q ? -rem_q : rem_q;
        valid_o <= 1'b1;
      end
    end
  end
endmodule
